keccak_squeeze: RTL and testbench

- Output (squeeze) end of the Keccak sponge datapath.
- Accepts a permuted 5x5xW state from the permutation core and streams rate lanes out one per cycle over a valid/ready handshake.
- When the rate is exhausted and more output is owed, requests another permutation (SHAKE/XOF output) and waits for the next state.
- Sits between the Keccak-f round engine and the digest/output FIFO.

---
 rtl/keccak_pkg.sv | 14 +
 rtl/keccak_lane_mux.sv | 20 ++
 rtl/keccak_squeeze.sv | 81 ++++++++
 tb/tb_keccak_squeeze.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// keccak_pkg: shared types, lane-order tables, rate constants and squeeze FSM states
package keccak_pkg;
  localparam int LANE_W = 64;
  typedef logic [4:0][4:0][LANE_W-1:0] state_t;
  localparam int RATE_SHA3_224 = 18;
  localparam int RATE_SHA3_256 = 17;
  localparam int RATE_SHA3_384 = 13;
  localparam int RATE_SHA3_512 = 9;
  localparam int RATE_SHAKE128 = 21;
  localparam int RATE_SHAKE256 = 17;
  localparam logic [24:0][2:0] LANE_X = {5{3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
  localparam logic [24:0][2:0] LANE_Y = {{5{3'd4}}, {5{3'd3}}, {5{3'd2}}, {5{3'd1}}, {5{3'd0}}};
  typedef enum logic [1:0] {IDLE, EMIT, WAIT_PERM} sq_state_e;
endpackage

// File: rtl/keccak_lane_mux.sv
// keccak_lane_mux: lane index to state lane selector; KECCAK_SQUEEZE_BYTESWAP_EN reverses bytes
module keccak_lane_mux
  import keccak_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [4:0][4:0][W-1:0] buf_i,
  input  logic [4:0]             idx_i,
  output logic [W-1:0]           lane_o
);
  logic [W-1:0] l;
  assign l = buf_i[LANE_X[idx_i]][LANE_Y[idx_i]];
`ifdef KECCAK_SQUEEZE_BYTESWAP_EN
  for (genvar b = 0; b < W / 8; b++) begin : g_sw
    assign lane_o[8*b +: 8] = l[W-8-8*b +: 8];
  end
`else
  assign lane_o = l;
`endif
endmodule

// File: rtl/keccak_squeeze.sv
// keccak_squeeze: streams rate lanes of permuted states, requesting permutations until len lanes are out
module keccak_squeeze
  import keccak_pkg::*;
#(
  parameter int W          = 64,
  parameter int RATE_LANES = 17,
  parameter int LEN_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0][4:0][W-1:0] state_in,
  input  logic [LEN_W-1:0]       len_in,
  input  logic                   state_valid,
  output logic                   state_ready,
  output logic                   perm_req,
  output logic [W-1:0]           out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy
);
  sq_state_e              st_q;
  logic [4:0][4:0][W-1:0] buf_q;
  logic [LEN_W-1:0]       rem_q;
  logic [4:0]             idx_q;
  logic                   valid_q, last_q, req_q;
  assign state_ready = (st_q == IDLE) || (st_q == WAIT_PERM);
  assign busy        = st_q != IDLE;
  assign out_valid   = valid_q;
  assign out_last    = last_q;
  assign perm_req    = req_q;
  keccak_lane_mux #(.W(W)) u_mux (.buf_i(buf_q), .idx_i(idx_q), .lane_o(out_data));
  // squeeze FSM: latch states, count lanes out, ask for permutations when the rate runs dry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      buf_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      case (st_q)
        IDLE: if (state_valid) begin
          buf_q   <= state_in;
          rem_q   <= len_in;
          idx_q   <= '0;
          st_q    <= len_in != '0 ? EMIT : IDLE;
          valid_q <= len_in != '0;
          last_q  <= len_in == LEN_W'(1);
        end
        EMIT: if (out_ready) begin
          rem_q <= rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            st_q    <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end else if (idx_q == 5'(RATE_LANES - 1)) begin
            st_q    <= WAIT_PERM;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            req_q   <= 1'b1;
          end else begin
            idx_q  <= idx_q + 5'd1;
            last_q <= rem_q == LEN_W'(2);
          end
        end
        WAIT_PERM: if (state_valid) begin
          buf_q   <= state_in;
          st_q    <= EMIT;
          valid_q <= 1'b1;
          last_q  <= rem_q == LEN_W'(1);
          req_q   <= 1'b0;
        end
        default: st_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_keccak_squeeze.sv
// tb_keccak_squeeze: scoreboard bench with a lane-order reference model; honours KECCAK_SQUEEZE_BYTESWAP_EN
module tb_keccak_squeeze;
  localparam int RATE = 17;
  typedef logic [4:0][4:0][63:0] st_t;
  logic clk = 0, rst_n = 0;
  st_t state_in;
  logic [15:0] len_in;
  logic state_valid, state_ready, perm_req, out_valid, out_ready, out_last, busy;
  logic [63:0] out_data;
  int passed = 0, total = 0, xfers = 0, rmode = 0;
  logic tog = 0;
  logic [64:0] exq[$];
  st_t blk[$];
  keccak_squeeze #(.W(64), .RATE_LANES(RATE), .LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .state_in(state_in), .len_in(len_in), .state_valid(state_valid),
    .state_ready(state_ready), .perm_req(perm_req), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  function automatic logic [63:0] sw(input logic [63:0] v);
`ifdef KECCAK_SQUEEZE_BYTESWAP_EN
    for (int i = 0; i < 8; i++) sw[8*i +: 8] = v[8*(7-i) +: 8];
`else
    sw = v;
`endif
  endfunction
  function automatic st_t nib_state();
    for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++) nib_state[x][y] = 64'(y * 16 + x);
  endfunction
  function automatic st_t rnd_state();
    for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++) rnd_state[x][y] = {$urandom, $urandom};
  endfunction
  // monitor: pop the expected lane on every transfer and check stability across stalls
  logic ps = 0;
  logic [64:0] pv;
  always @(negedge clk) begin
    if (!rst_n) ps = 0;
    else begin
      if (ps && out_valid) chk("stall_hold", {7'd0, out_last, out_data}, {7'd0, pv});
      if (out_valid && out_ready) begin
        xfers++;
        if (exq.size() == 0) chk("unexpected_lane", {7'd0, out_last, out_data}, 72'h1_dead);
        else chk("lane", {7'd0, out_last, out_data}, {7'd0, exq.pop_front()});
      end
      ps = out_valid && !out_ready;
      pv = {out_last, out_data};
    end
  end
  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk); #1;
      tog = ~tog;
      out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? tog : 1'($urandom_range(0, 1));
    end
  end
  task automatic present(input st_t s, input logic [15:0] l);
    int n = 0;
    state_in = s; len_in = l; state_valid = 1;
    while (!state_ready && n < 200) begin @(negedge clk); #1; n++; end
    if (!state_ready) chk("state_ready_timeout", 0, 1);
    @(posedge clk); #1;
    state_valid = 0; len_in = 16'($urandom);
  endtask
  task automatic run(input int L);
    int n;
    for (int k = 0; k < L; k++)
      exq.push_back({k == L - 1, sw(blk[k / RATE][(k % RATE) % 5][(k % RATE) / 5])});
    present(blk[0], 16'(L));
    chk("first_valid", out_valid, L != 0);
    for (int b = 1; b * RATE < L; b++) begin
      n = 0;
      while (!perm_req && n < 2000) begin @(negedge clk); #1; n++; end
      chk("perm_wait", {perm_req, out_valid, state_ready}, 3'b101);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 present(blk[b], 16'($urandom));
    end
    n = 0;
    while ((busy || exq.size() != 0) && n < 5000) begin @(negedge clk); #1; n++; end
    chk("drain", {busy, 32'(exq.size())}, 0);
    blk.delete();
  endtask
  initial begin
    int n;
    st_t aa;
    state_valid = 0; state_in = '0; len_in = 0;
    for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++) aa[x][y] = 64'hAAAA_AAAA_AAAA_AAAA;
    #12;
    chk("reset_outs", {out_valid, out_last, perm_req, busy, state_ready, out_data}, {5'b00001, 64'd0});
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("post_reset", {out_valid, out_last, perm_req, busy, state_ready}, 5'b00001);
    blk.push_back(nib_state());
    for (int k = 0; k < 4; k++) exq.push_back({k == 3, sw(64'(k))});
    present(blk[0], 16'd4);
    blk.delete();
    n = 0;
    while (out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("throughput4", n, 4);
    chk("idle_ready", {busy, state_ready, 32'(exq.size())}, {2'b01, 32'd0});
    blk.push_back(nib_state()); blk.push_back(aa);
    run(20);
    rmode = 1;
    blk.push_back(rnd_state());
    run(5);
    rmode = 0;
    present(rnd_state(), 16'd0);
    for (int i = 0; i < 5; i++) begin
      chk("len0", {out_valid, busy, state_ready}, 3'b001);
      @(negedge clk);
    end
`ifdef KECCAK_SQUEEZE_BYTESWAP_EN
    aa[0][0] = 64'h0102_0304_0506_0708;
    exq.push_back({1'b1, 64'h0807_0605_0403_0201});
    present(aa, 16'd1);
    repeat (3) @(negedge clk);
    chk("byteswap_drain", 32'(exq.size()), 0);
`endif
    for (int j = 0; j < 8; j++) begin
      int L = $urandom_range(1, 60);
      rmode = $urandom_range(0, 2);
      for (int b = 0; b * RATE < L; b++) blk.push_back(rnd_state());
      run(L);
    end
    rmode = 0;
    blk.push_back(rnd_state());
    for (int k = 0; k < 10; k++) exq.push_back({k == 9, sw(blk[0][k % 5][k / 5])});
    n = xfers;
    present(blk[0], 16'd10);
    blk.delete();
    while (xfers < n + 3) begin @(negedge clk); #1; end
    rst_n = 0;
    #1 chk("async_reset", {out_valid, perm_req, busy}, 3'b000);
    exq.delete();
    @(posedge clk); #1 rst_n = 1;
    blk.push_back(nib_state());
    run(2);
    chk("after_reset_count", xfers, n + 5);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
